memory_port_arbiter: RTL and testbench
======================================

Name: memory_port_arbiter

Overview:
- Shares one single-read-port / single-write-port 16-bit memory block between two requesters, A (processor) and B (device/DMA).
- The memory block has 1-cycle registered read latency and separate read and write addresses.
- The arbiter grants each cycle with a valid/ready handshake and tracks in-flight reads so each response returns to the requester that issued it.
- One read and one write from different requesters proceed in the same cycle; all other collisions are resolved round-robin.

Parameters:
- WIDTH, 8, memory address width in bits; depth is 1 << WIDTH words.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- a_valid  input  1  requester A has a request.
- a_write  input  1  1 = write, 0 = read.
- a_address  input  WIDTH  A word address.
- a_data  input  16  A write data.
- a_ready  output  1  A request accepted this cycle (combinational).
- a_resp_valid  output  1  A read data valid (registered, 1-cycle pulse).
- a_resp_data  output  16  A read data.
- b_valid, b_write, b_address, b_data, b_ready, b_resp_valid, b_resp_data: same as A, for requester B.
- mem_write_enable  output  1  to memory write enable.
- mem_write_address  output  WIDTH  to memory write address.
- mem_data_in  output  16  to memory write data.
- mem_read_address  output  WIDTH  to memory read address.
- mem_data_out  input  16  from memory registered read data.

Behaviour:
- State: priority register (0 = A favoured, 1 = B favoured) and read-owner pipeline register {pending, owner}.
- Reset values: priority = 0; pending = 0; a/b_resp_valid = 0; a/b_resp_data = 0.
- While reset is high, a_ready = b_ready = 0 and mem_write_enable = 0.
- Handshake:
  - Transfer occurs when valid and ready are both high.
  - Requester holds valid, write, address and data stable until ready.
  - ready never depends on ready.
  - Responses have no backpressure.
- Grant rules (combinational, per cycle):
  - Only one valid: granted.
  - Both valid, different types (one read, one write), addresses differ: both granted.
  - Both valid, same type: the priority side is granted; the other gets ready = 0.
  - Both valid, different types, same address: the priority side is granted, the other stalls.
    - If the read wins, it returns the pre-write value.
    - If the write wins, the stalled read retries and sees the new value.
- Priority update: whenever exactly one of two valid requests is denied, priority points to the denied side next cycle; otherwise it holds.
- Memory drive:
  - mem_write_enable = 1 only for a granted write; mem_write_address and mem_data_in come from that requester.
  - mem_read_address comes from the granted reader, else 0.
  - Write addresses and data are 0 when no write is granted.
- Read latency:
  - Read granted at cycle N: pending = 1 and owner is latched at edge N.
  - During cycle N+1, mem_data_out is valid; resp_data is registered from it, so x_resp_valid = 1 and x_resp_data hold the data during cycle N+2.
  - Total request-to-response latency is 2 cycles, fully pipelined: one read per cycle sustained, and responses return in issue order.
  - The non-owner's resp_valid = 0; resp_data holds its last value.
- Writes produce no response.
- Reset mid-operation: the in-flight read is dropped and no response is issued after reset deasserts. Requesters must reissue.
- Address width: the full WIDTH bits are passed through; no wrap or truncation is performed by the arbiter.

Test Plan:
- Write then read: A writes 0x1234 @0x05, then reads @0x05 → a_ready = 1 both cycles; a_resp_valid 2 cycles after read grant with 0x1234; b_resp_valid stays 0.
- Read/write overlap, different addresses: A reads @0x10 (holds 0x00AA) while B writes 0x5555 @0x11 in the same cycle → both ready = 1; A gets 0x00AA; a later read @0x11 returns 0x5555.
- Same-address collision: priority = A; A writes 0xBEEF @0x20 while B reads @0x20 (holds 0x0001) → A granted, b_ready = 0; B granted next cycle and receives 0xBEEF.
- Same-type collision: both read continuously for 6 cycles → grants alternate A, B, A, B…; each response is tagged to the correct requester; no cycle with both ready.
- Back-to-back reads: A reads @0..3 on consecutive cycles → four consecutive a_resp_valid cycles with data in order.
- Reset mid-read: assert reset 1 cycle after a read is granted → a_resp_valid stays 0 through and after reset; priority = 0; ready = 0 while reset is high.

Source files
------------

// File: rtl/memory_port_arbiter_if.sv
// memory_port_arbiter_if: requester A/B handshake, response and memory-side bus of the arbiter
interface memory_port_arbiter_if #(parameter int WIDTH = 8);
    logic             a_valid, a_write, a_ready, a_resp_valid;
    logic [WIDTH-1:0] a_address;
    logic [15:0]      a_data, a_resp_data;
    logic             b_valid, b_write, b_ready, b_resp_valid;
    logic [WIDTH-1:0] b_address;
    logic [15:0]      b_data, b_resp_data;
    logic             mem_write_enable;
    logic [WIDTH-1:0] mem_write_address, mem_read_address;
    logic [15:0]      mem_data_in, mem_data_out;
    modport slave (
        input  a_valid, a_write, a_address, a_data, b_valid, b_write, b_address, b_data, mem_data_out,
        output a_ready, a_resp_valid, a_resp_data, b_ready, b_resp_valid, b_resp_data,
        output mem_write_enable, mem_write_address, mem_data_in, mem_read_address
    );
    modport master (
        output a_valid, a_write, a_address, a_data, b_valid, b_write, b_address, b_data, mem_data_out,
        input  a_ready, a_resp_valid, a_resp_data, b_ready, b_resp_valid, b_resp_data,
        input  mem_write_enable, mem_write_address, mem_data_in, mem_read_address
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: round-robin sharing of a 1R/1W 16-bit memory between requesters A and B
module memory_port_arbiter #(parameter int WIDTH = 8) (
    input logic                  clock,
    input logic                  reset,
    memory_port_arbiter_if.slave bus
);
    logic        prio_q, prio_d, pend_q, owner_q;
    logic        a_rv_q, b_rv_q;
    logic [15:0] a_rd_q, b_rd_q;
    logic        both, pair_ok, a_gnt, b_gnt, a_wg, b_wg, a_rg, b_rg;

    // grant decision: a read/write pair on distinct addresses goes together, anything else favours prio_q
    always_comb begin
        both    = bus.a_valid & bus.b_valid;
        pair_ok = (bus.a_write ^ bus.b_write) & (bus.a_address != bus.b_address);
        a_gnt   = !reset && bus.a_valid && (!bus.b_valid || pair_ok || !prio_q);
        b_gnt   = !reset && bus.b_valid && (!bus.a_valid || pair_ok || prio_q);
        a_wg    = a_gnt & bus.a_write;
        b_wg    = b_gnt & bus.b_write;
        a_rg    = a_gnt & !bus.a_write;
        b_rg    = b_gnt & !bus.b_write;
        prio_d  = (both && !pair_ok) ? !prio_q : prio_q;
    end

    assign bus.a_ready           = a_gnt;
    assign bus.b_ready           = b_gnt;
    assign bus.mem_write_enable  = a_wg | b_wg;
    assign bus.mem_write_address = a_wg ? bus.a_address : b_wg ? bus.b_address : '0;
    assign bus.mem_data_in       = a_wg ? bus.a_data : b_wg ? bus.b_data : '0;
    assign bus.mem_read_address  = a_rg ? bus.a_address : b_rg ? bus.b_address : '0;
    assign bus.a_resp_valid      = a_rv_q;
    assign bus.a_resp_data       = a_rd_q;
    assign bus.b_resp_valid      = b_rv_q;
    assign bus.b_resp_data       = b_rd_q;

    // owner tag rides alongside the memory's read stage; response is registered one cycle later
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_q  <= 1'b0;
            pend_q  <= 1'b0;
            owner_q <= 1'b0;
            a_rv_q  <= 1'b0;
            b_rv_q  <= 1'b0;
            a_rd_q  <= '0;
            b_rd_q  <= '0;
        end else begin
            prio_q  <= prio_d;
            pend_q  <= a_rg | b_rg;
            owner_q <= b_rg;
            a_rv_q  <= pend_q & !owner_q;
            b_rv_q  <= pend_q & owner_q;
            a_rd_q  <= (pend_q & !owner_q) ? bus.mem_data_out : a_rd_q;
            b_rd_q  <= (pend_q & owner_q) ? bus.mem_data_out : b_rd_q;
        end
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed vector table plus reset corner sequences against a 1-cycle memory model
module tb_memory_port_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] mem [256];

    typedef struct {
        logic        av, aw;
        logic [7:0]  aa;
        logic [15:0] ad;
        logic        bv, bw;
        logic [7:0]  ba;
        logic [15:0] bd;
        logic        ear, ebr, ewe, earv;
        logic [15:0] eard;
        logic        ebrv;
        logic [15:0] ebrd;
    } vec_t;

    vec_t tbl [22];

    memory_port_arbiter_if #(.WIDTH(8)) bus ();
    memory_port_arbiter #(.WIDTH(8)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    always @(posedge clock) begin
        bus.mem_data_out <= mem[bus.mem_read_address];
        if (bus.mem_write_enable) mem[bus.mem_write_address] <= bus.mem_data_in;
    end

    function automatic vec_t v(int av, int aw, int aa, int ad, int bv, int bw, int ba, int bd,
                               int ear, int ebr, int ewe, int earv, int eard, int ebrv, int ebrd);
        vec_t r;
        r.av = 1'(av); r.aw = 1'(aw); r.aa = 8'(aa); r.ad = 16'(ad);
        r.bv = 1'(bv); r.bw = 1'(bw); r.ba = 8'(ba); r.bd = 16'(bd);
        r.ear = 1'(ear); r.ebr = 1'(ebr); r.ewe = 1'(ewe);
        r.earv = 1'(earv); r.eard = 16'(eard); r.ebrv = 1'(ebrv); r.ebrd = 16'(ebrd);
        return r;
    endfunction

    task automatic drive(input vec_t r);
        bus.a_valid = r.av; bus.a_write = r.aw; bus.a_address = r.aa; bus.a_data = r.ad;
        bus.b_valid = r.bv; bus.b_write = r.bw; bus.b_address = r.ba; bus.b_data = r.bd;
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 4; i++) mem[i] = 16'h1000 + 16'(i);
        mem[8'h10] = 16'h00AA;
        mem[8'h20] = 16'h0001;
        tbl[0]  = v(1,1,'h05,'h1234, 0,0,0,0,       1,0,1, 0,'h0000, 0,'h0000);
        tbl[1]  = v(1,0,'h05,0,      0,0,0,0,       1,0,0, 0,'h0000, 0,'h0000);
        tbl[2]  = v(1,0,'h10,0,      1,1,'h11,'h5555, 1,1,1, 0,'h0000, 0,'h0000);
        tbl[3]  = v(0,0,0,0,         0,0,0,0,       0,0,0, 1,'h1234, 0,'h0000);
        tbl[4]  = v(1,0,'h11,0,      0,0,0,0,       1,0,0, 1,'h00AA, 0,'h0000);
        tbl[5]  = v(1,1,'h20,'hBEEF, 1,0,'h20,0,    1,0,1, 0,'h00AA, 0,'h0000);
        tbl[6]  = v(0,0,0,0,         1,0,'h20,0,    0,1,0, 1,'h5555, 0,'h0000);
        tbl[7]  = v(0,0,0,0,         0,0,0,0,       0,0,0, 0,'h5555, 0,'h0000);
        tbl[8]  = v(1,0,0,0,         1,0,1,0,       0,1,0, 0,'h5555, 1,'hBEEF);
        tbl[9]  = v(1,0,0,0,         1,0,1,0,       1,0,0, 0,'h5555, 0,'hBEEF);
        tbl[10] = v(1,0,0,0,         1,0,1,0,       0,1,0, 0,'h5555, 1,'h1001);
        tbl[11] = v(1,0,0,0,         1,0,1,0,       1,0,0, 1,'h1000, 0,'h1001);
        tbl[12] = v(1,0,0,0,         1,0,1,0,       0,1,0, 0,'h1000, 1,'h1001);
        tbl[13] = v(1,0,0,0,         1,0,1,0,       1,0,0, 1,'h1000, 0,'h1001);
        tbl[14] = v(0,0,0,0,         0,0,0,0,       0,0,0, 0,'h1000, 1,'h1001);
        tbl[15] = v(0,0,0,0,         0,0,0,0,       0,0,0, 1,'h1000, 0,'h1001);
        tbl[16] = v(1,0,0,0,         0,0,0,0,       1,0,0, 0,'h1000, 0,'h1001);
        tbl[17] = v(1,0,1,0,         0,0,0,0,       1,0,0, 0,'h1000, 0,'h1001);
        tbl[18] = v(1,0,2,0,         0,0,0,0,       1,0,0, 1,'h1000, 0,'h1001);
        tbl[19] = v(1,0,3,0,         0,0,0,0,       1,0,0, 1,'h1001, 0,'h1001);
        tbl[20] = v(0,0,0,0,         0,0,0,0,       0,0,0, 1,'h1002, 0,'h1001);
        tbl[21] = v(0,0,0,0,         0,0,0,0,       0,0,0, 1,'h1003, 0,'h1001);

        drive(v(1,1,'h05,'h1234, 1,0,'h06,0, 0,0,0,0,0,0,0));
        @(posedge clock); #1;
        @(posedge clock); #4;
        chk("reset_ready", -1, {14'b0, bus.a_ready, bus.b_ready}, 16'h0000);
        chk("reset_we", -1, {15'b0, bus.mem_write_enable}, 16'h0000);
        chk("reset_resp_valid", -1, {14'b0, bus.a_resp_valid, bus.b_resp_valid}, 16'h0000);
        chk("reset_a_data", -1, bus.a_resp_data, 16'h0000);
        chk("reset_b_data", -1, bus.b_resp_data, 16'h0000);
        @(posedge clock); #1;
        drive(v(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            @(posedge clock); #1;
            drive(tbl[i]);
            #4;
            chk("ready", i, {14'b0, bus.a_ready, bus.b_ready}, {14'b0, tbl[i].ear, tbl[i].ebr});
            chk("we", i, {15'b0, bus.mem_write_enable}, {15'b0, tbl[i].ewe});
            chk("a_resp_valid", i, {15'b0, bus.a_resp_valid}, {15'b0, tbl[i].earv});
            chk("a_resp_data", i, bus.a_resp_data, tbl[i].eard);
            chk("b_resp_valid", i, {15'b0, bus.b_resp_valid}, {15'b0, tbl[i].ebrv});
            chk("b_resp_data", i, bus.b_resp_data, tbl[i].ebrd);
        end

        @(posedge clock); #1;
        drive(v(1,0,'h05,0, 0,0,0,0, 0,0,0,0,0,0,0));
        #4;
        chk("mid_read_grant", 100, {15'b0, bus.a_ready}, 16'h0001);
        @(posedge clock); #1;
        reset = 1'b1;
        #4;
        chk("mid_reset_ready", 101, {15'b0, bus.a_ready}, 16'h0000);
        chk("mid_reset_resp", 101, {15'b0, bus.a_resp_valid}, 16'h0000);
        @(posedge clock); #5;
        chk("mid_reset_ready", 102, {15'b0, bus.a_ready}, 16'h0000);
        chk("mid_reset_resp", 102, {15'b0, bus.a_resp_valid}, 16'h0000);
        @(posedge clock); #1;
        drive(v(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #5;
            chk("post_reset_resp", 103 + i, {14'b0, bus.a_resp_valid, bus.b_resp_valid}, 16'h0000);
            chk("post_reset_data", 103 + i, bus.a_resp_data, 16'h0000);
        end
        @(posedge clock); #1;
        drive(v(1,0,0,0, 1,0,1,0, 0,0,0,0,0,0,0));
        #4;
        chk("post_reset_prio", 106, {14'b0, bus.a_ready, bus.b_ready}, 16'h0002);
        @(posedge clock); #1;
        drive(v(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
